// File: rtl/diila_reader.sv
// diila_reader: Wishbone master that programs and arms a diila logic analyzer, waits, then
// reads back the trace and streams it as 32-bit words. Optional ack timeout: DIILA_READER_TIMEOUT_EN.
module diila_reader #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] cfg_trig_i,
  input  logic [9:0]  cfg_post_i,
  input  logic [31:0] cfg_skip_i,
  input  logic [31:0] cfg_wait_i,
  output logic [21:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned DATA_WORDS = DATA_WIDTH / 32;
  localparam logic [9:0]  K_LAST     = 10'(DEPTH - 1);
  localparam logic [2:0]  R_LAST     = 3'(DATA_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_POST, S_WR_SKIP, S_WR_ARM, S_WAIT, S_RD, S_OUT, S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d, we_q, we_d;
  logic [21:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d, wait_q, wait_d, odata_q, odata_d;
  logic [9:0]  k_q, k_d;
  logic [2:0]  r_q, r_d;
  logic        valid_q, valid_d, last_q, last_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        abort_pend_q, abort_pend_d;
  logic        tmo_hit_c, bus_state_c, bus_end_c, bus_fail_c, stop_c;
  state_e      next_bus_c;

`ifdef DIILA_READER_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts cycles of an outstanding bus cycle; restarts whenever cyc is low.
  always_comb begin
    tmo_d = '0;
    if (cyc_q && !wb_ack_i && !wb_err_i) tmo_d = tmo_q + TMO_W'(1);
  end
  assign tmo_hit_c = cyc_q && !wb_ack_i && !wb_err_i && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) tmo_q <= '0;
    else             tmo_q <= tmo_d;
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  assign bus_state_c = (state_q == S_WR_POST) || (state_q == S_WR_SKIP) ||
                       (state_q == S_WR_ARM)  || (state_q == S_RD);
  assign bus_end_c   = cyc_q && (wb_ack_i || wb_err_i || tmo_hit_c);
  assign bus_fail_c  = cyc_q && (wb_err_i || tmo_hit_c);
  assign stop_c      = abort_i || abort_pend_q;

  always_comb begin
    next_bus_c = S_OUT;
    case (state_q)
      S_WR_POST: next_bus_c = S_WR_SKIP;
      S_WR_SKIP: next_bus_c = S_WR_ARM;
      S_WR_ARM:  next_bus_c = S_WAIT;
      default:   next_bus_c = S_OUT;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; bus states only leave once their cycle has ended.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_WR_POST;
      S_WR_POST, S_WR_SKIP, S_WR_ARM, S_RD: begin
        if (!cyc_q && stop_c)              state_d = S_FIN;
        else if (bus_end_c)                state_d = (bus_fail_c || stop_c) ? S_FIN : next_bus_c;
      end
      S_WAIT: begin
        if (abort_i)                       state_d = S_FIN;
        else if (wait_q == 32'd0)          state_d = S_RD;
      end
      S_OUT: begin
        if (abort_i)                       state_d = S_FIN;
        else if (out_ready_i)              state_d = last_q ? S_FIN : S_RD;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs and datapath.
  always_comb begin
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    wait_d       = wait_q;
    odata_d      = odata_q;
    k_d          = k_q;
    r_d          = r_q;
    valid_d      = valid_q;
    last_d       = last_q;
    error_d      = error_q;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FIN);
    abort_pend_d = bus_state_c && (abort_pend_q || abort_i) && (state_d != S_FIN);

    if (state_q == S_IDLE && start_i) begin
      error_d = 1'b0;
      k_d     = '0;
      r_d     = '0;
    end

    if (bus_state_c && !cyc_q && state_d == state_q) begin
      cyc_d = 1'b1;
      case (state_q)
        S_WR_POST: begin adr_d = 22'd1; dat_d = {22'd0, cfg_post_i}; we_d = 1'b1; end
        S_WR_SKIP: begin adr_d = 22'd2; dat_d = cfg_skip_i;          we_d = 1'b1; end
        S_WR_ARM:  begin adr_d = 22'd0; dat_d = cfg_trig_i;          we_d = 1'b1; end
        default:   begin adr_d = {12'(r_q), k_q}; dat_d = '0;        we_d = 1'b0; end
      endcase
    end

    if (bus_end_c) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
    end
    if (bus_fail_c) error_d = 1'b1;

    if (state_q == S_RD && state_d == S_OUT) begin
      odata_d = wb_dat_i;
      valid_d = 1'b1;
      last_d  = (k_q == K_LAST) && (r_q == R_LAST);
    end

    if (state_q == S_WR_ARM && state_d == S_WAIT) wait_d = cfg_wait_i;
    else if (state_q == S_WAIT && wait_q != 32'd0) wait_d = wait_q - 32'd1;

    if (state_q == S_OUT && (abort_i || out_ready_i)) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (!abort_i) begin
        if (r_q == R_LAST) begin
          r_d = '0;
          k_d = k_q + 10'd1;
        end else begin
          r_d = r_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      wait_q       <= '0;
      odata_q      <= '0;
      k_q          <= '0;
      r_q          <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      wait_q       <= wait_d;
      odata_q      <= odata_d;
      k_q          <= k_d;
      r_q          <= r_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = 4'hf;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign out_data_o  = odata_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_diila_reader.sv
// Bench for diila_reader: address-echo Wishbone slave, trace scoreboard, config vector table
// and hand sequences for backpressure, abort, bus error, timeout and mid-dump reset.
module tb_diila_reader;
  localparam int unsigned DW    = 96;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;
  localparam int unsigned NW    = DW / 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, ready = 1'b1;
  logic [31:0] cfg_trig = '0, cfg_skip = '0, cfg_wait = '0;
  logic [9:0]  cfg_post = '0;
  logic [21:0] adr;
  logic [31:0] dat_o, out_data;
  logic [3:0]  sel;
  logic        we, cyc, stb, out_valid, out_last, busy, done, error;
  logic [31:0] dat_i;
  logic        ack, err;
  logic        ack_en = 1'b1, err_en = 1'b0;
  logic [21:0] err_adr = '0;

  always #5 clk = ~clk;

  diila_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .cfg_trig_i(cfg_trig), .cfg_post_i(cfg_post), .cfg_skip_i(cfg_skip), .cfg_wait_i(cfg_wait),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_we_o(we), .wb_cyc_o(cyc),
    .wb_stb_o(stb), .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_err_i(err),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(ready), .out_last_o(out_last),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, xfer_cnt = 0, gap_viol = 0, cyc_run = 0, last_cyc_len = 0;
  bit prev_end = 1'b0;
  logic [54:0] bus_log[$];
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Registered slave: echoes the word address as read data, optional error injection.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0; err <= 1'b0; dat_i <= '0;
    end else begin
      ack <= 1'b0; err <= 1'b0;
      if (cyc && stb && !ack && !err) begin
        if (err_en && we && adr == err_adr) err <= 1'b1;
        else if (ack_en)                    ack <= 1'b1;
        dat_i <= {10'd0, adr};
      end
    end
  end

  // Monitor: bus transfer log, gap rule, done pulses and trace scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cyc && stb && (ack || err)) bus_log.push_back({we, adr, dat_o});
      if (cyc && prev_end) gap_viol++;
      prev_end = cyc && (ack || err);
      if (cyc) cyc_run++;
      else begin
        if (cyc_run != 0) last_cyc_len = cyc_run;
        cyc_run = 0;
      end
      if (done) done_cnt++;
      if (out_valid && ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("out_unexpected", 64'({out_last, out_data}), 64'h1_FFFF_FFFF);
        else check("out_word", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_expected();
    for (int k = 0; k < int'(DEPTH); k++)
      for (int r = 0; r <= int'(NW); r++)
        exp_q.push_back({(k == int'(DEPTH) - 1 && r == int'(NW)), 10'd0, 12'(r), 10'(k)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [31:0] trig; logic [9:0] post; logic [31:0] skip; logic [31:0] wt;
    logic [31:0] e1; logic [31:0] e2; logic [31:0] e0;
  } vec_t;
  vec_t vecs[3];

  initial begin
    bit ok;
    int d0, g0, n0, x0;
    logic [31:0] held;
    bit stable, cyc_quiet;

    vecs[0] = '{32'h0000_00A5, 10'd32,   32'h0,         32'd0, 32'h20,  32'h0,         32'hA5};
    vecs[1] = '{32'hDEAD_BEEF, 10'd1023, 32'h1234_5678, 32'd5, 32'h3FF, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0,         10'd0,    32'hFFFF_FFFF, 32'd1, 32'h0,   32'hFFFF_FFFF, 32'h0};

    // Reset state
    #12;
    check("rst_cyc", 64'(cyc), 0);        check("rst_stb", 64'(stb), 0);
    check("rst_we", 64'(we), 0);          check("rst_adr", 64'(adr), 0);
    check("rst_dat", 64'(dat_o), 0);      check("rst_sel", 64'(sel), 64'hf);
    check("rst_valid", 64'(out_valid), 0); check("rst_last", 64'(out_last), 0);
    check("rst_data", 64'(out_data), 0);  check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);      check("rst_error", 64'(error), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Config vectors: full dump each, checking writes, first read and trace
    for (int v = 0; v < 3; v++) begin
      cfg_trig = vecs[v].trig; cfg_post = vecs[v].post;
      cfg_skip = vecs[v].skip; cfg_wait = vecs[v].wt;
      bus_log.delete(); g0 = gap_viol; d0 = done_cnt;
      push_expected();
      pulse_start();
      wait_done(3000, ok);
      check("vec_done", 64'(ok), 1);
      repeat (3) @(negedge clk);
      check("vec_nbus", 64'(bus_log.size()), 64'(3 + DEPTH * (NW + 1)));
      if (bus_log.size() >= 19) begin
        check("vec_wr1", 64'(bus_log[0]), 64'({1'b1, 22'd1, vecs[v].e1}));
        check("vec_wr2", 64'(bus_log[1]), 64'({1'b1, 22'd2, vecs[v].e2}));
        check("vec_wr0", 64'(bus_log[2]), 64'({1'b1, 22'd0, vecs[v].e0}));
        check("vec_rd0", 64'(bus_log[3][54:32]), 64'({1'b0, 22'h000}));
        check("vec_rdlast", 64'(bus_log[18][54:32]), 64'({1'b0, 22'hC03}));
      end
      check("vec_sb_empty", 64'(exp_q.size()), 0);
      check("vec_done_once", 64'(done_cnt - d0), 1);
      check("vec_busy", 64'(busy), 0);
      check("vec_error", 64'(error), 0);
      check("vec_gap", 64'(gap_viol - g0), 0);
    end

    // Backpressure at word 3
    cfg_wait = 32'd0; bus_log.delete(); x0 = xfer_cnt;
    push_expected();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (xfer_cnt - x0 == 3) begin ok = 1'b1; break; end
    end
    ready = 1'b0;
    check("bp_reach3", 64'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("bp_valid", 64'(ok), 1);
    held = out_data; n0 = bus_log.size(); stable = 1'b1; cyc_quiet = 1'b1;
    check("bp_word3", 64'(held), 64'h0C00);
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_data !== held) stable = 1'b0;
      if (cyc) cyc_quiet = 1'b0;
    end
    check("bp_stable", 64'(stable), 1);
    check("bp_cyc_low", 64'(cyc_quiet), 1);
    check("bp_no_read", 64'(bus_log.size() - n0), 0);
    ready = 1'b1;
    wait_done(3000, ok);
    check("bp_done", 64'(ok), 1);
    check("bp_sb_empty", 64'(exp_q.size()), 0);

    // Abort during WAIT
    cfg_wait = 32'd1000; bus_log.delete();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_log.size() == 3) begin ok = 1'b1; break; end
    end
    check("ab_armed", 64'(ok), 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(2, ok);
    check("ab_done_fast", 64'(ok), 1);
    repeat (3) @(negedge clk);
    check("ab_busy", 64'(busy), 0);
    check("ab_no_read", 64'(bus_log.size()), 3);

    // Bus error on the skip write
    cfg_wait = 32'd0; err_en = 1'b1; err_adr = 22'd2; bus_log.delete(); d0 = done_cnt;
    pulse_start();
    wait_done(200, ok);
    check("er_done", 64'(ok), 1);
    repeat (2) @(negedge clk);
    check("er_error", 64'(error), 1);
    check("er_nbus", 64'(bus_log.size()), 2);
    if (bus_log.size() >= 2) check("er_adr", 64'(bus_log[1][53:32]), 2);
    check("er_done_once", 64'(done_cnt - d0), 1);
    err_en = 1'b0;
    push_expected();
    pulse_start();
    @(negedge clk);
    check("er_cleared", 64'(error), 0);
    wait_done(3000, ok);
    check("er_rerun_done", 64'(ok), 1);
    check("er_sb_empty", 64'(exp_q.size()), 0);

    // Slave never acks
    ack_en = 1'b0; bus_log.delete();
    pulse_start();
`ifdef DIILA_READER_TIMEOUT_EN
    wait_done(200, ok);
    check("to_done", 64'(ok), 1);
    repeat (2) @(negedge clk);
    check("to_error", 64'(error), 1);
    check("to_cyc_len", 64'(last_cyc_len), 64'(TMO));
    check("to_cyc_low", 64'(cyc), 0);
`else
    repeat (100) @(negedge clk);
    check("to_cyc_held", 64'(cyc), 1);
    check("to_no_error", 64'(error), 0);
`endif
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("to_rst_cyc", 64'(cyc), 0);
    check("to_rst_busy", 64'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1; ack_en = 1'b1;

    // Reset mid-dump
    x0 = xfer_cnt;
    push_expected();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (xfer_cnt - x0 >= 5) begin ok = 1'b1; break; end
    end
    check("mr_progress", 64'(ok), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check("mr_valid", 64'(out_valid), 0);
    check("mr_cyc", 64'(cyc), 0);
    check("mr_busy", 64'(busy), 0);
    check("mr_done_lvl", 64'(done), 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mr_no_done", 64'(done_cnt - d0), 0);
    check("mr_idle", 64'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
